branch_cache_ctrl: RTL and testbench

BRANCH_CACHE_CTRL -- requirements
Module: branch_cache_ctrl

---
 rtl/branch_cache_ctrl.sv | 176 +++++++++++++++++
 tb/tb_branch_cache_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cache_ctrl.sv
// Arbitration controller for a branch-prediction cache with a single tag path:
// it queues resolved-branch updates, ages the queue head, and drives a one-cycle cache flush.
module branch_cache_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AGE_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_req,
    input  logic [9:0] fetch_pc,
    output logic       fetch_grant,
    output logic       pred_hit,
    output logic       pred_taken,
    input  logic       upd_valid,
    input  logic [9:0] upd_pc,
    input  logic       upd_taken,
    output logic       upd_ready,
    input  logic       flush,
    output logic       busy,
    output logic [9:0] cache_pc,
    output logic [9:0] cache_update_pc,
    output logic       cache_we,
    output logic       cache_branch_taken,
    output logic       cache_rst,
    input  logic       cache_read_hit,
    input  logic [2:0] cache_read_history,
    input  logic       cache_evict,
    output logic [7:0] evict_count
);

    localparam int unsigned PC_W  = 10;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
    localparam int unsigned EVC_W = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PC_W-1:0]    r_fifo_pc    [FIFO_DEPTH];
    logic               r_fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [AGE_W-1:0]   r_head_age;
    logic [EVC_W-1:0]   r_evict_count;

    logic               w_full;
    logic               w_update_sel;
    logic               w_push;
    logic               w_pop;
    logic               w_hist_major;
    logic               w_evict_inc;

    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_hist_major = (cache_read_history[0] & cache_read_history[1]) |
                          (cache_read_history[0] & cache_read_history[2]) |
                          (cache_read_history[1] & cache_read_history[2]);
    assign w_push       = upd_valid && upd_ready;
    assign w_pop        = w_update_sel;
    assign w_evict_inc  = cache_we && cache_evict && (r_evict_count != {EVC_W{1'b1}});

    // Read and write share one index, so both cache address ports carry the same PC.
    assign cache_update_pc = cache_pc;
    assign evict_count     = r_evict_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Cache ownership: a pending update wins when fetch is idle, the FIFO is full or the head is stale.
    always_comb begin
        w_state_nxt        = r_state;
        w_update_sel       = 1'b0;
        fetch_grant        = 1'b0;
        pred_hit           = 1'b0;
        pred_taken         = 1'b0;
        upd_ready          = 1'b0;
        busy               = 1'b0;
        cache_pc           = '0;
        cache_we           = 1'b0;
        cache_branch_taken = 1'b0;
        cache_rst          = 1'b0;

        if (rst) begin
            cache_rst = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    upd_ready    = (r_count < CNT_W'(FIFO_DEPTH));
                    w_update_sel = (r_count != '0) &&
                                   (!fetch_req || w_full ||
                                    (r_head_age >= AGE_W'(AGE_LIMIT)));
                    if (flush) begin
                        w_state_nxt = ST_FLUSH;
                    end
                    if (w_update_sel) begin
                        cache_pc           = r_fifo_pc[r_rd_ptr];
                        cache_we           = 1'b1;
                        cache_branch_taken = r_fifo_taken[r_rd_ptr];
                    end else if (fetch_req) begin
                        cache_pc    = fetch_pc;
                        fetch_grant = 1'b1;
                        pred_hit    = cache_read_hit;
                        pred_taken  = cache_read_hit && w_hist_major;
                    end
                end
                ST_FLUSH: begin
                    w_state_nxt = ST_RUN;
                    cache_rst   = 1'b1;
                    busy        = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= upd_pc;
            r_fifo_taken[r_wr_ptr] <= upd_taken;
        end
    end

    // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head_age <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head_age <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop || (r_count == '0)) begin
                r_head_age <= '0;
            end else if (r_head_age < AGE_W'(AGE_LIMIT)) begin
                r_head_age <= r_head_age + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evict_count <= '0;
        end else if (w_evict_inc) begin
            r_evict_count <= r_evict_count + EVC_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_cache_ctrl.sv
// Randomized bench for branch_cache_ctrl: a behavioural cache and a queue-based
// reference model predict every output each cycle.
module tb_branch_cache_ctrl;

    localparam int DEPTH = 4;
    localparam int ALIM  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req;
    logic [9:0] fetch_pc;
    logic       fetch_grant;
    logic       pred_hit;
    logic       pred_taken;
    logic       upd_valid;
    logic [9:0] upd_pc;
    logic       upd_taken;
    logic       upd_ready;
    logic       flush;
    logic       busy;
    logic [9:0] cache_pc;
    logic [9:0] cache_update_pc;
    logic       cache_we;
    logic       cache_branch_taken;
    logic       cache_rst;
    logic       cache_read_hit;
    logic [2:0] cache_read_history;
    logic       cache_evict;
    logic [7:0] evict_count;

    branch_cache_ctrl #(.FIFO_DEPTH(DEPTH), .AGE_LIMIT(ALIM)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_grant(fetch_grant),
        .pred_hit(pred_hit), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .flush(flush), .busy(busy),
        .cache_pc(cache_pc), .cache_update_pc(cache_update_pc), .cache_we(cache_we),
        .cache_branch_taken(cache_branch_taken), .cache_rst(cache_rst),
        .cache_read_hit(cache_read_hit), .cache_read_history(cache_read_history),
        .cache_evict(cache_evict), .evict_count(evict_count)
    );

    always #5 clk = ~clk;

    // Behavioural cache: 16 entries indexed by pc[3:0], tagged by pc[9:4], 3-bit outcome history.
    logic       c_valid [16];
    logic [5:0] c_tag   [16];
    logic [2:0] c_hist  [16];

    function automatic logic lookup_hit(input logic [9:0] pc);
        return c_valid[pc[3:0]] && (c_tag[pc[3:0]] == pc[9:4]);
    endfunction

    function automatic int votes(input logic [9:0] pc);
        logic [2:0] h;
        h = c_hist[pc[3:0]];
        return int'(h[0]) + int'(h[1]) + int'(h[2]);
    endfunction

    assign cache_read_hit     = lookup_hit(cache_pc);
    assign cache_read_history = c_hist[cache_pc[3:0]];
    assign cache_evict        = cache_we && !lookup_hit(cache_update_pc);

    always @(posedge clk) begin
        if (cache_rst) begin
            for (int i = 0; i < 16; i++) c_valid[i] <= 1'b0;
        end else if (cache_we) begin
            if (lookup_hit(cache_update_pc)) begin
                c_hist[cache_update_pc[3:0]] <= {c_hist[cache_update_pc[3:0]][1:0], cache_branch_taken};
            end else begin
                c_valid[cache_update_pc[3:0]] <= 1'b1;
                c_tag[cache_update_pc[3:0]]   <= cache_update_pc[9:4];
                c_hist[cache_update_pc[3:0]]  <= {2'b00, cache_branch_taken};
            end
        end
    end

    typedef struct {
        logic [9:0] pc;
        logic       tk;
    } upd_t;

    upd_t q[$];
    int   m_age;
    int   m_evict;
    bit   m_flush;

    logic       e_grant, e_hit, e_tk, e_ready, e_busy, e_we, e_bt, e_crst, e_sel;
    logic [9:0] e_pc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict outputs from model state and current inputs, then compare.
    task automatic settle();
        #3;
        if (rst) begin
            q.delete();
            m_age   = 0;
            m_flush = 0;
            m_evict = 0;
        end
        {e_grant, e_hit, e_tk, e_ready, e_busy, e_we, e_bt, e_crst, e_sel} = '0;
        e_pc = '0;
        if (rst) begin
            e_crst = 1'b1;
        end else if (m_flush) begin
            e_crst = 1'b1;
            e_busy = 1'b1;
        end else begin
            e_ready = (q.size() < DEPTH);
            e_sel   = (q.size() > 0) && (!fetch_req || q.size() == DEPTH || m_age >= ALIM);
            if (e_sel) begin
                e_pc = q[0].pc;
                e_we = 1'b1;
                e_bt = q[0].tk;
            end else if (fetch_req) begin
                e_pc    = fetch_pc;
                e_grant = 1'b1;
                e_hit   = lookup_hit(fetch_pc);
                e_tk    = e_hit && (votes(fetch_pc) >= 2);
            end
        end
        chk("fetch_grant", 32'(fetch_grant), 32'(e_grant));
        chk("pred_hit", 32'(pred_hit), 32'(e_hit));
        chk("pred_taken", 32'(pred_taken), 32'(e_tk));
        chk("upd_ready", 32'(upd_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cache_pc", 32'(cache_pc), 32'(e_pc));
        chk("cache_update_pc", 32'(cache_update_pc), 32'(e_pc));
        chk("cache_we", 32'(cache_we), 32'(e_we));
        chk("cache_branch_taken", 32'(cache_branch_taken), 32'(e_bt));
        chk("cache_rst", 32'(cache_rst), 32'(e_crst));
        chk("evict_count", 32'(evict_count), 32'(m_evict));
    endtask

    // Advance the model across the rising edge, then step to just after it.
    task automatic tick();
        if (!rst) begin
            if (m_flush) begin
                m_flush = 0;
                q.delete();
                m_age = 0;
            end else begin
                int n;
                n = q.size();
                if (e_we && !lookup_hit(e_pc) && m_evict < 255) m_evict++;
                if (e_sel) void'(q.pop_front());
                if (upd_valid && e_ready) q.push_back(upd_t'{pc: upd_pc, tk: upd_taken});
                if (e_sel || n == 0) m_age = 0;
                else if (m_age < ALIM) m_age++;
                if (flush) m_flush = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            c_valid[i] = 1'b0;
            c_tag[i]   = '0;
            c_hist[i]  = '0;
        end
        q.delete();
        m_age = 0; m_evict = 0; m_flush = 0;

        // Reset held with busy inputs: everything quiet except cache_rst.
        rst = 1'b1; fetch_req = 1'b1; fetch_pc = 10'h135;
        upd_valid = 1'b1; upd_pc = 10'h003; upd_taken = 1'b1; flush = 1'b1;
        repeat (3) begin
            settle();
            chk("rst_upd_ready", 32'(upd_ready), 32'd0);
            chk("rst_cache_rst", 32'(cache_rst), 32'd1);
            tick();
        end
        rst = 1'b0; flush = 1'b0; upd_valid = 1'b0;

        // Cold lookup.
        fetch_req = 1'b1; fetch_pc = 10'h135;
        settle();
        chk("cold_grant", 32'(fetch_grant), 32'd1);
        chk("cold_hit", 32'(pred_hit), 32'd0);
        chk("cold_we", 32'(cache_we), 32'd0);
        chk("first_ready", 32'(upd_ready), 32'd1);
        tick();

        // Three taken updates to 0x135, then a hitting, taken lookup.
        fetch_req = 1'b0; upd_valid = 1'b1; upd_pc = 10'h135; upd_taken = 1'b1;
        cycle();
        settle();
        chk("first_write_we", 32'(cache_we), 32'd1);
        chk("first_write_evict", 32'(cache_evict), 32'd1);
        tick();
        cycle();
        upd_valid = 1'b0;
        cycle();
        fetch_req = 1'b1; fetch_pc = 10'h135;
        settle();
        chk("trained_hit", 32'(pred_hit), 32'd1);
        chk("trained_taken", 32'(pred_taken), 32'd1);
        chk("trained_evicts", 32'(evict_count), 32'd1);
        tick();

        // Head ageing: one update stalls four cycles behind fetch.
        upd_valid = 1'b1; upd_pc = 10'h2A0; upd_taken = 1'b0;
        cycle();
        upd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall_grant", 32'(fetch_grant), 32'd1);
            chk("stall_we", 32'(cache_we), 32'd0);
            tick();
        end
        settle();
        chk("aged_we", 32'(cache_we), 32'd1);
        chk("aged_grant", 32'(fetch_grant), 32'd0);
        tick();

        // Full FIFO pre-empts fetch and refuses further updates.
        upd_valid = 1'b1; upd_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            upd_pc = 10'h041 + 10'(i);
            cycle();
        end
        upd_valid = 1'b0;
        settle();
        chk("full_ready", 32'(upd_ready), 32'd0);
        chk("full_we", 32'(cache_we), 32'd1);
        chk("full_head_pc", 32'(cache_pc), 32'h041);
        tick();
        fetch_req = 1'b0;
        repeat (5) cycle();

        // Flush with two updates pending.
        fetch_req = 1'b1; fetch_pc = 10'h135;
        upd_valid = 1'b1; upd_pc = 10'h0A6;
        cycle();
        upd_pc = 10'h0A7;
        cycle();
        upd_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        settle();
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_cache_rst", 32'(cache_rst), 32'd1);
        tick();
        settle();
        chk("post_flush_ready", 32'(upd_ready), 32'd1);
        chk("post_flush_hit", 32'(pred_hit), 32'd0);
        tick();
        fetch_req = 1'b0;
        repeat (3) cycle();

        // Reset mid-operation drops pending updates at once.
        fetch_req = 1'b1; upd_valid = 1'b1; upd_pc = 10'h055;
        cycle();
        cycle();
        upd_valid = 1'b0; rst = 1'b1;
        settle();
        chk("midrst_ready", 32'(upd_ready), 32'd0);
        chk("midrst_grant", 32'(fetch_grant), 32'd0);
        tick();
        rst = 1'b0; fetch_req = 1'b0;
        repeat (3) cycle();

        // Evict counter saturation.
        upd_valid = 1'b1;
        for (int i = 0; i < 302; i++) begin
            upd_pc    = (i % 2 == 0) ? 10'h010 : 10'h020;
            upd_taken = 1'($urandom_range(0, 1));
            cycle();
        end
        upd_valid = 1'b0;
        repeat (3) cycle();
        settle();
        chk("evict_saturated", 32'(evict_count), 32'd255);
        tick();

        // Random traffic over a small PC pool so hits, aliases and evictions occur.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            fetch_req = ($urandom_range(0, 99) < 60);
            fetch_pc  = 10'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
            upd_valid = ($urandom_range(0, 99) < 50);
            upd_pc    = 10'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
            upd_taken = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 999) < 5);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; upd_valid = 1'b0; fetch_req = 1'b0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
